// File: rtl/tqvp_pdm_cic_fifo.sv
// PDM microphone front end: PDM clock, 1-2 channel CIC3 decimation and a PCM frame FIFO.
// Define TQVP_PDM_OVF_IRQ_EN to also drive user_interrupt from the sticky overflow flag.
module tqvp_pdm_cic_fifo #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ACC_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pdm_dat_i,
  output logic        pdm_clk_o,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic        en_q;
  logic [7:0]  period_q, per_act_q, phase_q, per_eff;
  logic [12:0] decim_q;
  logic [7:0]  r_act_q, r_eff, dec_cnt_q;
  logic [4:0]  sh_act_q, sh_pipe_q;
  logic [5:0]  thresh_q, level;
  logic        ovf_q, pdm_prev_q, pend_q, comb_vld_q;
  logic [1:0]  warm_q, cap;
  logic        wr_en, rd_en, last0, frame_done, push_v, pop, flush, empty, full;
  logic signed [ACC_W-1:0] integ_q [2][3];
  logic signed [ACC_W-1:0] dly_q [2][3];
  logic signed [ACC_W-1:0] comb_q [2];
  logic signed [ACC_W-1:0] step, i1n [2], i2n [2], i3n [2], fval [2], c1 [2], c2 [2], c3 [2];
  logic signed [ACC_W-1:0] shv [2];
  logic [15:0] sat [2];
  logic [31:0] entry;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic        unused_data;

  assign unused_data = ^data_in[31:13];
  assign data_ready  = 1'b1;
  assign wr_en       = (data_write_n != 2'b11);
  assign rd_en       = (data_read_n != 2'b11);

  assign per_eff   = (period_q < 8'd2) ? 8'd2 : period_q;
  assign r_eff     = (decim_q[7:0] < 8'd4) ? 8'd4 : decim_q[7:0];
  assign pdm_clk_o = en_q && (phase_q < (per_act_q >> 1));

  // pdm_prev_q parks at 1 while disabled so the first high phase is not seen as a ch1 edge.
  assign cap[0]     = en_q && pdm_prev_q && !pdm_clk_o;
  assign cap[1]     = (CHANNELS == 2) && en_q && !pdm_prev_q && pdm_clk_o;
  assign last0      = cap[0] && (dec_cnt_q == r_act_q - 8'd1);
  assign frame_done = (CHANNELS == 2) ? (cap[1] && pend_q) : last0;

  always_comb begin
    step = pdm_dat_i ? ACC_W'(1) : '1;
    for (int c = 0; c < 2; c++) begin
      i1n[c]  = integ_q[c][0] + step;
      i2n[c]  = integ_q[c][1] + i1n[c];
      i3n[c]  = integ_q[c][2] + i2n[c];
      fval[c] = cap[c] ? i3n[c] : integ_q[c][2];
      c1[c]   = fval[c] - dly_q[c][0];
      c2[c]   = c1[c] - dly_q[c][1];
      c3[c]   = c2[c] - dly_q[c][2];
      shv[c]  = comb_q[c] >>> sh_pipe_q;
      if ((&shv[c][ACC_W-1:15]) || !(|shv[c][ACC_W-1:15])) begin
        sat[c] = shv[c][15:0];
      end else begin
        sat[c] = shv[c][ACC_W-1] ? 16'h8000 : 16'h7fff;
      end
    end
  end

  assign entry = {(CHANNELS == 2) ? sat[1] : 16'h0000, sat[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      period_q   <= '0;
      decim_q    <= '0;
      thresh_q   <= '0;
      per_act_q  <= '0;
      phase_q    <= '0;
      r_act_q    <= '0;
      sh_act_q   <= '0;
      sh_pipe_q  <= '0;
      dec_cnt_q  <= '0;
      pend_q     <= 1'b0;
      warm_q     <= '0;
      comb_vld_q <= 1'b0;
      pdm_prev_q <= 1'b1;
      for (int c = 0; c < 2; c++) begin
        comb_q[c] <= '0;
        for (int s = 0; s < 3; s++) begin
          integ_q[c][s] <= '0;
          dly_q[c][s]   <= '0;
        end
      end
    end else begin
      if (wr_en && address == 6'h00) en_q <= data_in[0];
      if (wr_en && address == 6'h04) period_q <= data_in[7:0];
      if (wr_en && address == 6'h08) decim_q <= data_in[12:0];
      if (wr_en && address == 6'h14) thresh_q <= data_in[5:0];
      if (!en_q) begin
        phase_q    <= '0;
        per_act_q  <= per_eff;
        r_act_q    <= r_eff;
        sh_act_q   <= decim_q[12:8];
        dec_cnt_q  <= '0;
        pend_q     <= 1'b0;
        warm_q     <= '0;
        comb_vld_q <= 1'b0;
        pdm_prev_q <= 1'b1;
        for (int c = 0; c < 2; c++) begin
          comb_q[c] <= '0;
          for (int s = 0; s < 3; s++) begin
            integ_q[c][s] <= '0;
            dly_q[c][s]   <= '0;
          end
        end
      end else begin
        pdm_prev_q <= pdm_clk_o;
        if (phase_q == per_act_q - 8'd1) begin
          phase_q   <= '0;
          per_act_q <= per_eff;
        end else begin
          phase_q <= phase_q + 8'd1;
        end
        if (cap[0]) dec_cnt_q <= last0 ? 8'd0 : dec_cnt_q + 8'd1;
        if (frame_done) pend_q <= 1'b0;
        if (last0) pend_q <= 1'b1;
        for (int c = 0; c < 2; c++) begin
          if (cap[c]) begin
            integ_q[c][0] <= i1n[c];
            integ_q[c][1] <= i2n[c];
            integ_q[c][2] <= i3n[c];
          end
        end
        comb_vld_q <= frame_done && (warm_q == 2'd3);
        if (frame_done) begin
          // The finished frame keeps the shift it was accumulated under.
          r_act_q   <= r_eff;
          sh_act_q  <= decim_q[12:8];
          sh_pipe_q <= sh_act_q;
          if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
          for (int c = 0; c < 2; c++) begin
            dly_q[c][0] <= fval[c];
            dly_q[c][1] <= c1[c];
            dly_q[c][2] <= c2[c];
            comb_q[c]   <= c3[c];
          end
        end
      end
    end
  end

  assign push_v = comb_vld_q && en_q;
  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop    = rd_en && (address == 6'h0C) && !empty;
  assign flush  = wr_en && (address == 6'h00) && data_in[1];
  assign level  = 6'(wp_q - rp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push_v && (!full || pop)) wp_q <= wp_q + 1'b1;
        if (pop) rp_q <= rp_q + 1'b1;
      end
      if (wr_en && address == 6'h10 && data_in[10]) ovf_q <= 1'b0;
      if (push_v && full && !pop && !flush) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_v && (!full || pop) && !flush) mem_q[wp_q[AW-1:0]] <= entry;
  end

  always_comb begin
    data_out = 32'h0;
    case (address)
      6'h00:   data_out = {31'h0, en_q};
      6'h04:   data_out = {24'h0, period_q};
      6'h08:   data_out = {19'h0, decim_q};
      6'h0C:   data_out = empty ? 32'h0 : mem_q[rp_q[AW-1:0]];
      6'h10:   data_out = {21'h0, ovf_q, full, empty, 2'b00, level};
      6'h14:   data_out = {26'h0, thresh_q};
      default: data_out = 32'h0;
    endcase
  end

`ifdef TQVP_PDM_OVF_IRQ_EN
  assign user_interrupt = ((thresh_q != 6'd0) && (level >= thresh_q)) || ovf_q;
`else
  assign user_interrupt = (thresh_q != 6'd0) && (level >= thresh_q);
`endif

endmodule

// File: tb/tb_tqvp_pdm_cic_fifo.sv
// Directed bench: one mono and one stereo instance share the register bus.
module tb_tqvp_pdm_cic_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic        pclk_m, pclk_s, dat_m, dat_s, rdy_m, rdy_s, irq_m, irq_s;
  logic [31:0] dout_m, dout_s;
  int          checks = 0;
  int          errors = 0;

`ifdef TQVP_PDM_OVF_IRQ_EN
  localparam logic OvfIrq = 1'b1;
`else
  localparam logic OvfIrq = 1'b0;
`endif

  always #5 clk = ~clk;

  assign dat_m = 1'b1;
  // ch0 samples just after the falling PDM edge (sees 1), ch1 after the rising edge (sees 0).
  assign dat_s = ~pclk_s;

  tqvp_pdm_cic_fifo #(.CHANNELS(1), .FIFO_DEPTH(8), .ACC_W(26)) u_mono (
    .clk(clk), .rst(rst), .pdm_dat_i(dat_m), .pdm_clk_o(pclk_m), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(dout_m), .data_ready(rdy_m), .user_interrupt(irq_m)
  );

  tqvp_pdm_cic_fifo #(.CHANNELS(2), .FIFO_DEPTH(8), .ACC_W(26)) u_stereo (
    .clk(clk), .rst(rst), .pdm_dat_i(dat_s), .pdm_clk_o(pclk_s), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(dout_s), .data_ready(rdy_s), .user_interrupt(irq_s)
  );

  typedef struct {
    string       name;
    logic        do_wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write_n = 2'b10;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] vs, output logic [31:0] vm);
    address = a;
    #1;
    vs = dout_s;
    vm = dout_m;
  endtask

  task automatic pop(output logic [31:0] vs, output logic [31:0] vm);
    @(negedge clk);
    address = 6'h0C;
    data_read_n = 2'b00;
    #1;
    vs = dout_s;
    vm = dout_m;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  // Polls the stereo level once per cycle; returns the cycles waited.
  task automatic wait_level(input int n, input int budget, output int cyc);
    cyc = 0;
    address = 6'h10;
    #1;
    while (dout_s[5:0] != n[5:0] && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("wait_level", {26'h0, dout_s[5:0]}, n);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [10];
    logic [31:0] vs, vm;
    int          cyc;

    vecs[0] = '{"rst_ctrl",   1'b0, 6'h00, 32'h0,         32'h0};
    vecs[1] = '{"rst_status", 1'b0, 6'h10, 32'h0,         32'h100};
    vecs[2] = '{"rst_fifo",   1'b0, 6'h0C, 32'h0,         32'h0};
    vecs[3] = '{"period_rw",  1'b1, 6'h04, 32'h1FF,       32'hFF};
    vecs[4] = '{"decim_rw",   1'b1, 6'h08, 32'hFFFF_FFFF, 32'h1FFF};
    vecs[5] = '{"thresh_rw",  1'b1, 6'h14, 32'hFF,        32'h3F};
    vecs[6] = '{"unmapped",   1'b1, 6'h18, 32'hFFFF,      32'h0};
    vecs[7] = '{"flush_bit",  1'b1, 6'h00, 32'h2,         32'h0};
    vecs[8] = '{"ovf_w1c",    1'b1, 6'h10, 32'h400,       32'h100};
    vecs[9] = '{"thresh_clr", 1'b1, 6'h14, 32'h0,         32'h0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pclk_s", {31'h0, pclk_s}, 32'h0);
    check("rst_pclk_m", {31'h0, pclk_m}, 32'h0);
    check("rst_irq", {31'h0, irq_s}, 32'h0);
    check("data_ready", {31'h0, rdy_s}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      peek(vecs[i].addr, vs, vm);
      check(vecs[i].name, vs, vecs[i].exp);
    end

    // Gain, warm-up and frame rate: PERIOD=4, R=64, SHIFT=4.
    wr(6'h04, 32'd4);
    wr(6'h08, 32'h440);
    wr(6'h00, 32'h1);
    wait_level(1, 1200, cyc);
    check("warmup_lat", {31'h0, (cyc >= 1010 && cyc <= 1040)}, 32'h1);
    wait_level(2, 300, cyc);
    check("frame_int", cyc, 256);
    pop(vs, vm);
    check("stereo_gain", vs, 32'hC000_4000);
    check("mono_gain", vm, 32'h0000_4000);

    // SHIFT=0 saturates both polarities; the in-flight frame keeps SHIFT=4.
    wr(6'h08, 32'h040);
    wr(6'h00, 32'h3);
    wait_level(2, 700, cyc);
    pop(vs, vm);
    pop(vs, vm);
    check("stereo_sat", vs, 32'h8000_7FFF);
    check("mono_sat", vm, 32'h0000_7FFF);

    // Threshold interrupt.
    wr(6'h08, 32'h440);
    wr(6'h14, 32'd4);
    wr(6'h00, 32'h3);
    wait_level(3, 1000, cyc);
    check("irq_lvl3", {31'h0, irq_s}, 32'h0);
    wait_level(4, 400, cyc);
    check("irq_lvl4", {31'h0, irq_s}, 32'h1);
    pop(vs, vm);
    peek(6'h10, vs, vm);
    check("pop_level", vs, 32'h3);
    check("pop_irq", {31'h0, irq_s}, 32'h0);

    // Overflow: SHIFT changes to 5 after 4 entries, so frames 6..8 are 0x2000.
    wr(6'h14, 32'd0);
    wr(6'h00, 32'h3);
    wait_level(4, 1300, cyc);
    wr(6'h08, 32'h540);
    wait_level(8, 1200, cyc);
    repeat (300) @(negedge clk);
    peek(6'h10, vs, vm);
    check("ovf_status_s", vs, 32'h608);
    check("ovf_status_m", vm, 32'h608);
    check("ovf_irq", {31'h0, irq_s}, {31'h0, OvfIrq});
    for (int i = 0; i < 8; i++) begin
      pop(vs, vm);
      check($sformatf("ovf_s%0d", i), vs, (i < 5) ? 32'hC000_4000 : 32'hE000_2000);
      check($sformatf("ovf_m%0d", i), vm, (i < 5) ? 32'h0000_4000 : 32'h0000_2000);
    end
    peek(6'h10, vs, vm);
    check("drained", vs, 32'h500);
    pop(vs, vm);
    check("empty_read", vs, 32'h0);
    peek(6'h10, vs, vm);
    check("empty_lvl", vs, 32'h500);
    wr(6'h10, 32'h400);
    peek(6'h10, vs, vm);
    check("ovf_clear", vs, 32'h100);
    check("ovf_clr_irq", {31'h0, irq_s}, 32'h0);

    // Flush with 5 entries.
    wr(6'h08, 32'h440);
    wait_level(5, 1700, cyc);
    wr(6'h00, 32'h3);
    peek(6'h10, vs, vm);
    check("flush5", vs, 32'h100);

    // Disable mid-frame keeps the FIFO; re-enable repeats the warm-up.
    wait_level(1, 400, cyc);
    repeat (128) @(negedge clk);
    wr(6'h00, 32'h0);
    #1;
    check("dis_pclk", {30'h0, pclk_s, pclk_m}, 32'h0);
    peek(6'h10, vs, vm);
    check("dis_keep", vs, 32'h1);
    wr(6'h00, 32'h3);
    wait_level(1, 1200, cyc);
    check("rewarm_lat", {31'h0, (cyc >= 1010 && cyc <= 1040)}, 32'h1);

    // Reset mid-frame.
    repeat (128) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_pclk", {30'h0, pclk_s, pclk_m}, 32'h0);
    check("rst_mid_irq", {30'h0, irq_s, irq_m}, 32'h0);
    peek(6'h10, vs, vm);
    check("rst_mid_stat", vs, 32'h100);
    peek(6'h04, vs, vm);
    check("rst_mid_per", vs, 32'h0);
    repeat (600) @(negedge clk);
    peek(6'h10, vs, vm);
    check("rst_no_push", vs, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tqvp_pdm_cic_fifo.md
# tqvp_pdm_cic_fifo

Parametrised PDM microphone interface for the TinyQV peripheral bus. It generates the PDM clock and captures one or two interleaved PDM channels from a shared data line. Each channel is decimated with its own 3rd-order CIC filter, and the resulting PCM frames are buffered in a FIFO. An interrupt signals FIFO level and overflow so software can drain samples in bursts instead of one per conversion.

## Interface
- CHANNELS, 2, number of PDM channels (1 or 2) sharing pdm_dat_i.
- FIFO_DEPTH, 8, FIFO entries (power of two, 2..32).
- ACC_W, 26, CIC accumulator width (supports R up to 256).
- clk  input  1  system clock.
- rst  input  1  reset. Synchronous and active-high, acting on the rising edge of clk.
- pdm_dat_i  input  1  PDM data, already synchronised to clk.
- pdm_clk_o  output  1  PDM clock to the microphones.
- address  input  6  register address.
- data_in  input  32  write data.
- data_write_n  input  2  11 = no write; any other value = write.
- data_read_n  input  2  11 = no read; any other value = read.
- data_out  output  32  read data, combinational from address.
- data_ready  output  1  constant 1.
- user_interrupt  output  1  level-sensitive interrupt.

## Operation
- **Register map**
  - 0x00 CTRL: [0] enable, [1] flush (self-clearing, empties FIFO).
  - 0x04 PERIOD[7:0]: clk cycles per PDM clock. Values below 2 act as 2.
  - 0x08 DECIM: [7:0] R, values below 4 act as 4; [12:8] SHIFT.
  - 0x0C FIFO pop/read.
  - 0x10 STATUS: [5:0] level, [8] empty, [9] full, [10] overflow (sticky, write 1 to clear).
  - 0x14 THRESH[5:0].
  - Unmapped addresses read 0.
- **Reset values:** all registers are 0, FIFO is empty, pdm_clk_o=0, user_interrupt=0, data_out follows address.
- **Clock generation**
  - Phase counter runs 0..PERIOD-1, and only while enabled.
  - pdm_clk_o=1 while phase < PERIOD>>1.
  - Disabling forces phase=0 and pdm_clk_o=0.
- **Capture**
  - ch0 samples pdm_dat_i in the clk cycle where pdm_clk_o goes 1→0.
  - ch1 samples it on 0→1.
  - With CHANNELS=1, only ch0 is used.
- **CIC, per channel**
  - Input bit 1 maps to +1, 0 to -1.
  - Three cascaded ACC_W-bit wrapping integrators update per captured bit.
  - A decimation counter counts ch0 bits 0..R-1. A frame completes when the R-th ch1 bit is captured (R-th ch0 bit when mono).
  - On frame completion, three comb stages (differential delay 1) run.
  - Output = comb >>> SHIFT, saturated to [-32768, 32767].
- **Warm-up:** the first 3 frames after enable rises are discarded.
- **FIFO**
  - Entry = {ch1[15:0], ch0[15:0]}; upper half is 0 when mono.
  - A frame push into a full FIFO is dropped and sets overflow.
  - A read of 0x0C (data_read_n≠11) pops one entry per cycle. It returns the head entry; an empty FIFO returns 0 with no pop.
  - Simultaneous push and pop when full: pop first, push succeeds, no overflow.
  - Flush empties the FIFO but leaves overflow unchanged. Flush in the same cycle as a push: FIFO ends empty.
- **Enable low:** clears integrators, combs, decimation counter and warm-up count. FIFO contents are retained.
- **Interrupt:** user_interrupt = (THRESH≠0 && level ≥ THRESH), optionally ORed with overflow (see Configuration).

## Timing
- Register writes take effect on the next clk.
- PERIOD and DECIM changes apply at the next phase and frame wrap respectively.
- Comb stages are registered one clk after frame completion. Saturation and push happen one clk later.
- The entry is visible at 0x0C, and level is updated, 2 clk after the pdm_clk_o edge that completed the frame.
- Pop takes effect on the clk edge ending the read cycle. Level and user_interrupt update the same edge.
- rst mid-frame: everything returns to reset values in one cycle, with no partial push.

## Configuration
- TQVP_PDM_OVF_IRQ_EN
  - Defined: user_interrupt also asserts while STATUS.overflow=1.
  - Undefined: overflow is visible in STATUS only and never drives the interrupt.

## Test plan
- **Mono gain, positive:** CHANNELS=1, PERIOD=4, R=64, SHIFT=4, pdm_dat_i=1 constant → after 3 discarded frames, each entry = 0x00004000. Entries arrive every 256 clk.
- **Stereo split and saturation:** CHANNELS=2, ch0 bits all 1, ch1 bits all 0, R=64, SHIFT=4 → entry 0xC0004000. Then SHIFT=0 → 0x80007FFF.
- **Threshold interrupt:** THRESH=4 → user_interrupt rises with the 4th push. One 0x0C read → level 3 and interrupt low on the same edge.
- **Overflow:** DEPTH=8, no reads, 9 frames → level 8, full=1, overflow=1. The 9th frame is lost; the first 8 read back in order. The interrupt asserts only with the macro defined. Writing 1 to STATUS[10] clears overflow.
- **Empty read and flush:** read 0x0C when empty → 0, level stays 0. Flush with 5 entries → empty=1 next cycle.
- **Reset and disable mid-frame:** assert rst halfway through a frame → pdm_clk_o=0, level 0, no push. Disable/enable → 3 frames discarded again.
